// File: rtl/traffic_gen_pkg.sv
// ---------------------------------------------------------------------------
// traffic_gen_pkg
// Shared definitions for the traffic generator: default stream geometry and
// the C2H arbiter state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package traffic_gen_pkg;

    localparam int DEF_C_DATA_WIDTH = 512;
    localparam int DEF_NUM_FLOWS    = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/c2h_flow_arbiter_if.sv
// ---------------------------------------------------------------------------
// c2h_flow_arbiter_if
// Bundles the NUM_FLOWS per-flow C2H streams and the single merged C2H
// stream toward the QDMA.
//   in_tdata/in_dpar/in_tvalid/in_tlast : per-flow stream, packed by flow
//   in_tready                           : per-flow ready
//   c2h_tdata/c2h_dpar/c2h_tvalid/c2h_tlast : merged stream
//   c2h_tready                          : ready from the QDMA
// Modports: slave = arbiter side, master = flows + QDMA side.
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// are both high; data/last are only meaningful while tvalid is high, and
// ready may be driven independently of valid.
// ---------------------------------------------------------------------------
interface c2h_flow_arbiter_if
    import traffic_gen_pkg::*;
#(
    parameter int C_DATA_WIDTH = DEF_C_DATA_WIDTH,
    parameter int NUM_FLOWS    = DEF_NUM_FLOWS
);
    logic [NUM_FLOWS*C_DATA_WIDTH-1:0]   in_tdata;
    logic [NUM_FLOWS*C_DATA_WIDTH/8-1:0] in_dpar;
    logic [NUM_FLOWS-1:0]                in_tvalid;
    logic [NUM_FLOWS-1:0]                in_tlast;
    logic [NUM_FLOWS-1:0]                in_tready;

    logic [C_DATA_WIDTH-1:0]             c2h_tdata;
    logic [C_DATA_WIDTH/8-1:0]           c2h_dpar;
    logic                                c2h_tvalid;
    logic                                c2h_tlast;
    logic                                c2h_tready;

    modport slave (
        input  in_tdata, in_dpar, in_tvalid, in_tlast,
        output in_tready,
        output c2h_tdata, c2h_dpar, c2h_tvalid, c2h_tlast,
        input  c2h_tready
    );

    modport master (
        output in_tdata, in_dpar, in_tvalid, in_tlast,
        input  in_tready,
        input  c2h_tdata, c2h_dpar, c2h_tvalid, c2h_tlast,
        output c2h_tready
    );

endinterface

// File: rtl/c2h_flow_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority picker. Searches req starting at
// (last_grant+1) mod N upward with wrap-around and returns the first set bit.
//   req        in  N   request vector
//   last_grant in  IW  most recently served index
//   valid      out 1   any request set
//   idx        out IW  chosen index (0 when valid is low)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after
    // last_grant is the one left standing.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = {1'b0, last_grant} + (IW+1)'(k);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/c2h_flow_arbiter.sv
// ---------------------------------------------------------------------------
// c2h_flow_arbiter
// Packet-atomic round-robin arbiter sharing the QDMA C2H stream between
// NUM_FLOWS flows, with per-flow completed-packet counters.
//   axi_aclk    in   clock
//   user_resetn in   asynchronous active-low reset
//   flow_en     in   per-flow arbitration enable
//   cnt_clr     in   synchronous clear of all packet counters
//   bus         slave modport: per-flow streams in, merged stream out
//   grant_id    out  current / last granted flow
//   busy        out  high while a packet is in flight (FSM state view)
//   pkt_count   out  completed packets per flow, CNT_WIDTH each, packed
// ---------------------------------------------------------------------------
module c2h_flow_arbiter
    import traffic_gen_pkg::*;
#(
    parameter int C_DATA_WIDTH = DEF_C_DATA_WIDTH,
    parameter int NUM_FLOWS    = DEF_NUM_FLOWS,
    parameter int CNT_WIDTH    = 32,
    localparam int GW          = $clog2(NUM_FLOWS)
) (
    input  logic                           axi_aclk,
    input  logic                           user_resetn,
    input  logic [NUM_FLOWS-1:0]           flow_en,
    input  logic                           cnt_clr,
    c2h_flow_arbiter_if.slave              bus,
    output logic [GW-1:0]                  grant_id,
    output logic                           busy,
    output logic [NUM_FLOWS*CNT_WIDTH-1:0] pkt_count
);

    localparam int PW = C_DATA_WIDTH / 8;

    arb_state_t           state;
    logic [GW-1:0]        last_grant;
    logic [NUM_FLOWS-1:0] req;
    logic                 pick_valid;
    logic [GW-1:0]        pick_idx;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 fire_last;
    logic [CNT_WIDTH-1:0] cnt_q [NUM_FLOWS];

    // flow_en only gates new grants; a packet already granted runs to tlast.
    assign req = bus.in_tvalid & flow_en;

    rr_pick #(.N(NUM_FLOWS), .IW(GW)) u_rr_pick (
        .req        (req),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    // Combinational mux on grant_id; data follows grant_id even in IDLE,
    // while valid/last/ready are forced low outside BUSY.
    always_comb begin
        bus.c2h_tdata = '0;
        bus.c2h_dpar  = '0;
        sel_valid     = 1'b0;
        sel_last      = 1'b0;
        bus.in_tready = '0;
        for (int i = 0; i < NUM_FLOWS; i++) begin
            if (grant_id == GW'(i)) begin
                bus.c2h_tdata = bus.in_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
                bus.c2h_dpar  = bus.in_dpar[i*PW +: PW];
                sel_valid     = bus.in_tvalid[i];
                sel_last      = bus.in_tlast[i];
                if (state == ARB_BUSY) begin
                    bus.in_tready[i] = bus.c2h_tready;
                end
            end
        end
        bus.c2h_tvalid = (state == ARB_BUSY) && sel_valid;
        bus.c2h_tlast  = (state == ARB_BUSY) && sel_last;
    end

    assign fire_last = bus.c2h_tvalid && bus.c2h_tready && bus.c2h_tlast;

    // Arbiter FSM. busy mirrors the state register so it can be observed.
    always_ff @(posedge axi_aclk or negedge user_resetn) begin
        if (!user_resetn) begin
            state      <= ARB_IDLE;
            grant_id   <= '0;
            last_grant <= GW'(NUM_FLOWS - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        state    <= ARB_BUSY;
                        busy     <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (fire_last) begin
                        last_grant <= grant_id;
                        state      <= ARB_IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Per-flow packet counters; clear wins over a same-cycle increment.
    always_ff @(posedge axi_aclk or negedge user_resetn) begin
        if (!user_resetn) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (fire_last && (grant_id == GW'(i))) begin
                    cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_FLOWS; g++) begin : g_cnt_pack
        assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
    end

endmodule

// File: doc/c2h_flow_arbiter.md
# c2h_flow_arbiter

Packet-atomic round-robin arbiter sharing the single QDMA C2H AXI-Stream port between NUM_FLOWS traffic-generator `flow` instances. Each flow presents a complete C2H stream (tdata/dpar/tvalid/tlast). The arbiter grants one flow at a time for a whole packet, then rotates. It sits between the `flow` instances and the QDMA C2H interface. It also keeps per-flow packet counters for the host control registers.

## Interface
Parameters:
- C_DATA_WIDTH, 512, C2H tdata width in bits.
- NUM_FLOWS, 4, number of requesting flows; legal range 2..16.
- CNT_WIDTH, 32, width of each per-flow packet counter.

Ports:
- axi_aclk  in  1  single clock for all logic.
- user_resetn  in  1  asynchronous, active-low reset.
- flow_en  in  NUM_FLOWS  per-flow arbitration enable (from control_reg).
- cnt_clr  in  1  synchronous clear of all packet counters.
- in_tdata  in  NUM_FLOWS*C_DATA_WIDTH  flow i occupies bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- in_dpar  in  NUM_FLOWS*C_DATA_WIDTH/8  per-flow parity, packed the same way as in_tdata.
- in_tvalid  in  NUM_FLOWS  per-flow valid.
- in_tlast  in  NUM_FLOWS  per-flow last beat.
- in_tready  out  NUM_FLOWS  per-flow ready.
- c2h_tdata  out  C_DATA_WIDTH  merged stream data.
- c2h_dpar  out  C_DATA_WIDTH/8  merged stream parity.
- c2h_tvalid  out  1  merged stream valid.
- c2h_tlast  out  1  merged stream last beat.
- c2h_tready  in  1  ready from QDMA.
- grant_id  out  $clog2(NUM_FLOWS)  index of the current or last granted flow.
- busy  out  1  high while a packet is in flight.
- pkt_count  out  NUM_FLOWS*CNT_WIDTH  completed packets per flow, packed the same way as in_tdata.

## Operation
The arbiter has two states, IDLE and BUSY.

IDLE:
- req = in_tvalid & flow_en.
- If req ≠ 0, pick the first set bit searching from (last_grant+1) mod NUM_FLOWS upward, with wrap-around.
- Register the result as grant_id and move to BUSY.
- No req → stay in IDLE.

BUSY:
- c2h_tdata, c2h_dpar, c2h_tvalid and c2h_tlast equal the inputs of flow grant_id.
- in_tready[grant_id] = c2h_tready. All other in_tready bits are 0.
- When c2h_tvalid & c2h_tready & c2h_tlast: pkt_count[grant_id] increments, last_grant ← grant_id, next state IDLE.

Boundary rules:
- flow_en[grant_id] dropping mid-packet does not abort the packet. The packet completes, and the flow is excluded from later arbitration.
- A granted flow may drop tvalid mid-packet. The arbiter stays in BUSY (no timeout), and c2h_tvalid follows the flow's tvalid.
- In IDLE: c2h_tvalid = 0, all in_tready bits = 0, and the c2h data outputs hold the grant_id mux value (don't-care).
- Counters wrap at 2^CNT_WIDTH−1 → 0.
- cnt_clr has priority over an increment in the same cycle: the result is 0.
- Single-beat packets (tvalid & tlast on the first beat) are legal: grant, transfer, return to IDLE.

Reset values:
- State IDLE, grant_id 0, last_grant NUM_FLOWS−1 (so flow 0 has first priority).
- busy 0, c2h_tvalid 0, in_tready 0, all pkt_count 0.

## Timing
- Arbitration costs one bubble cycle per packet: IDLE → BUSY on the first edge with req ≠ 0, and the first beat is accepted no earlier than the following cycle.
- Back-to-back packets on the port are separated by exactly 1 idle cycle when c2h_tready stays high.
- The data path is combinational from in_* to c2h_*, with no register stage. The ready path is combinational from c2h_tready to in_tready.
- busy = (state == BUSY), registered.
- pkt_count updates on the clock edge of the tlast handshake and is visible the next cycle.
- Asynchronous reset mid-packet: outputs go to their reset values immediately, and the partial packet is dropped. Upstream flows must be reset by the same user_resetn.

## Structure
- Shared package `traffic_gen_pkg`:
  - localparams for the default C_DATA_WIDTH and NUM_FLOWS.
  - a typedef for the arbiter state enum {ARB_IDLE, ARB_BUSY}.
- One sub-module `rr_pick`: combinational round-robin priority picker (inputs req, last_grant; outputs valid, idx). It is reusable for future credit schedulers.
- Counters and the mux are in the top module.

## Test plan
- Reset, then flow 0 only: send 3 packets of 64 beats with c2h_tready=1. Required: 3×64 beats on c2h in order, 1 idle cycle between packets, pkt_count[0]=3.
- All 4 flows continuously valid, 8-beat packets. Required: grant order 0,1,2,3,0,…; each pkt_count = 4 after 16 packets.
- Random backpressure on c2h_tready (50%) with flows 1 and 3 active. Required: no beat lost or duplicated; tlast count matches pkt_count[1]+pkt_count[3]; only the granted in_tready is ever high.
- Clear flow_en[2] at beat 5 of a 16-beat flow-2 packet. Required: all 16 beats complete, and flow 2 is never granted again while disabled.
- Preload pkt_count[0] to 2^32−1 through traffic, then send 1 more packet. Required: count becomes 0. In a separate scenario, assert cnt_clr in the same cycle as a tlast handshake. Required: count becomes 0.
- Assert user_resetn low during beat 10 of a packet. Required: c2h_tvalid=0 and in_tready=0 in the same cycle, and after reset the first grant goes to the lowest-index requesting flow.
